// File: rtl/lap_countdown_timer.sv
// Countdown timer with timed alarm, or count-up stopwatch with lap memory.
// Counts are in ticks produced by an internal prescaler that only runs in RUN/RING.
module lap_countdown_timer #(
  parameter int TICK_DIV   = 1000000,
  parameter int COUNT_W    = 32,
  parameter int LAP_DEPTH  = 8,
  parameter int RING_TICKS = 300,
  localparam int IDX_W     = $clog2(LAP_DEPTH),
  localparam int LC_W      = $clog2(LAP_DEPTH + 1)
) (
  input  logic               clockSignal,
  input  logic               resetSignal,
  input  logic               modeInput,
  input  logic               startOrStop,
  input  logic               splitOrReset,
  input  logic [COUNT_W-1:0] loadValue,
  input  logic [IDX_W-1:0]   lapReadIndex,
  output logic               mode,
  output logic               running,
  output logic [COUNT_W-1:0] countValue,
  output logic [COUNT_W-1:0] lapValue,
  output logic [LC_W-1:0]    lapCount,
  output logic               lapOverflow,
  output logic               ringSound
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int RW = $clog2(RING_TICKS + 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, RING} state_t;

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [LC_W-1:0]    lapcnt_q, lapcnt_d;
  logic               lapovf_q, lapovf_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [RW-1:0]      ring_q, ring_d;
  logic [COUNT_W-1:0] lapval_q, lapval_d;
  logic               running_q, ringsnd_q;
  logic               tick, lap_we;

  logic [COUNT_W-1:0] lap_mem [LAP_DEPTH];

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    count_d  = count_q;
    lapcnt_d = lapcnt_q;
    lapovf_d = lapovf_q;
    lap_we   = 1'b0;
    tick     = (state_q == RUN || state_q == RING) && (presc_q == PW'(TICK_DIV - 1));

    // Only the highest-priority pulse is considered; lower ones are dropped.
    unique case (state_q)
      IDLE: begin
        if (startOrStop) begin
          if (mode_q) state_d = RUN;
          else if (loadValue != '0) begin
            count_d = loadValue;
            state_d = RUN;
          end
        end else if (splitOrReset) begin
          count_d = '0;
          if (mode_q) begin
            lapcnt_d = '0;
            lapovf_d = 1'b0;
          end
        end else if (modeInput) begin
          mode_d   = ~mode_q;
          count_d  = '0;
          lapcnt_d = '0;
          lapovf_d = 1'b0;
        end
      end
      RUN: begin
        if (startOrStop) state_d = PAUSE;
        else begin
          if (splitOrReset && mode_q) begin
            if (lapcnt_q < LC_W'(LAP_DEPTH)) begin
              lap_we   = 1'b1;
              lapcnt_d = lapcnt_q + 1'b1;
            end else lapovf_d = 1'b1;
          end
          if (tick) begin
            if (mode_q) begin
              if (count_q != '1) count_d = count_q + 1'b1;
            end else if (count_q == COUNT_W'(1)) begin
              count_d = '0;
              state_d = RING;
            end else count_d = count_q - 1'b1;
          end
        end
      end
      PAUSE: begin
        if (startOrStop) state_d = RUN;
        else if (splitOrReset) begin
          count_d = '0;
          state_d = IDLE;
          if (mode_q) begin
            lapcnt_d = '0;
            lapovf_d = 1'b0;
          end
        end
      end
      RING: begin
        if (startOrStop || splitOrReset) state_d = IDLE;
        else if (tick && ring_q == RW'(RING_TICKS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Prescaler restarts on every entry to RUN/RING so resume waits a full tick.
    presc_d = presc_q;
    ring_d  = ring_q;
    if ((state_d == RUN || state_d == RING) && state_d != state_q) presc_d = '0;
    else if (state_q == RUN || state_q == RING) presc_d = tick ? '0 : presc_q + 1'b1;
    if (state_d == RING && state_q != RING) ring_d = '0;
    else if (state_q == RING && tick) ring_d = ring_q + 1'b1;

    lapval_d = (LC_W'(lapReadIndex) < lapcnt_q) ? lap_mem[lapReadIndex] : '0;
  end

  always_ff @(posedge clockSignal or posedge resetSignal) begin
    if (resetSignal) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      count_q   <= '0;
      lapcnt_q  <= '0;
      lapovf_q  <= 1'b0;
      presc_q   <= '0;
      ring_q    <= '0;
      lapval_q  <= '0;
      running_q <= 1'b0;
      ringsnd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      count_q   <= count_d;
      lapcnt_q  <= lapcnt_d;
      lapovf_q  <= lapovf_d;
      presc_q   <= presc_d;
      ring_q    <= ring_d;
      lapval_q  <= lapval_d;
      running_q <= (state_d == RUN);
      ringsnd_q <= (state_d == RING);
    end
  end

  // Lap storage has no reset; entries beyond lapCount are masked on read.
  always_ff @(posedge clockSignal) begin
    if (lap_we) lap_mem[lapcnt_q[IDX_W-1:0]] <= count_q;
  end

  assign mode        = mode_q;
  assign running     = running_q;
  assign countValue  = count_q;
  assign lapValue    = lapval_q;
  assign lapCount    = lapcnt_q;
  assign lapOverflow = lapovf_q;
  assign ringSound   = ringsnd_q;

endmodule
